jtag_debug_initiator: RTL and testbench



---
 rtl/jtag_debug_pkg.sv | 9 +
 rtl/jtag_tck_gen.sv | 29 ++
 rtl/jtag_debug_initiator.sv | 91 +++++++++
 tb/tb_jtag_debug_initiator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_debug_pkg.sv
// jtag_debug_pkg: shared FSM states, IR codes and default scan length for the virtual-JTAG debug initiator
package jtag_debug_pkg;
  localparam int DEFAULT_DR_WIDTH = 38;
  localparam logic [1:0] IR_OCIMEM = 2'b00;
  localparam logic [1:0] IR_TRACE = 2'b01;
  localparam logic [1:0] IR_BREAK = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} jtag_state_t;
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into TCK (low half first) and flags the clk edges where TCK rises and falls
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);
  localparam int PW = $clog2(2 * TCK_DIV);
  logic [PW-1:0] phase;
  always_comb begin
    tck_rise = enable && phase == PW'(TCK_DIV - 1);
    tck_fall = enable && phase == PW'(2 * TCK_DIV - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase <= '0;
      tck <= 1'b0;
    end else if (!enable) begin
      phase <= '0;
      tck <= 1'b0;
    end else begin
      phase <= tck_fall ? '0 : phase + PW'(1);
      tck <= tck_rise ? 1'b1 : tck_fall ? 1'b0 : tck;
    end
endmodule

// File: rtl/jtag_debug_initiator.sv
// jtag_debug_initiator: runs one IR/DR scan per command on the virtual-JTAG debug channel and returns the captured TDO word
// Optional scan_count output is enabled with JTAG_DEBUG_INIT_SCAN_COUNT_EN.
module jtag_debug_initiator
  import jtag_debug_pkg::*;
#(
  parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
  parameter int TCK_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DR_WIDTH-1:0] resp_dr,
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
  output logic [15:0]         scan_count,
`endif
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);
  localparam int CW = $clog2(DR_WIDTH + 1);
  jtag_state_t state, nxt;
  logic [DR_WIDTH-1:0] sr;
  logic [CW-1:0] bit_cnt;
  logic tck_rise, tck_fall, scanning;
  always_comb begin
    scanning = state inside {UIR, CDR, SDR, UDR, RTI};
    nxt = state;
    case (state)
      IDLE: nxt = cmd_valid ? UIR : IDLE;
      SDR: nxt = (tck_fall && bit_cnt == CW'(DR_WIDTH - 1)) ? UDR : SDR;
      RTI: nxt = tck_fall ? RESP : RTI;
      RESP: nxt = resp_ready ? IDLE : RESP;
      default: nxt = tck_fall ? jtag_state_t'(state + 3'd1) : state;
    endcase
  end
  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk(clk), .reset(reset), .enable(scanning),
    .tck(vji_tck), .tck_rise(tck_rise), .tck_fall(tck_fall)
  );
  // strobes and handshake flags are registered decodes of the next state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_dr <= '0;
      sr <= '0;
      bit_cnt <= '0;
      vji_tdi <= 1'b0;
      vji_ir_in <= 2'b00;
      {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= 5'b0;
    end else begin
      state <= nxt;
      cmd_ready <= nxt == IDLE;
      resp_valid <= nxt == RESP;
      vji_uir <= nxt == UIR;
      vji_cdr <= nxt == CDR;
      vji_sdr <= nxt == SDR;
      vji_udr <= nxt == UDR;
      vji_rti <= nxt == RTI;
      if (state == IDLE && cmd_valid) begin
        vji_ir_in <= cmd_ir;
        sr <= cmd_dr;
      end else if (state == SDR && tck_rise)
        sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
      if (tck_fall) begin
        vji_tdi <= (nxt == SDR) ? sr[0] : 1'b0;
        bit_cnt <= (state == SDR) ? bit_cnt + CW'(1) : '0;
      end
      if (state == RTI && tck_fall)
        resp_dr <= sr;
    end
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset)
      scan_count <= '0;
    else if (resp_valid && resp_ready)
      scan_count <= scan_count + 16'd1;
`endif
endmodule

// File: tb/tb_jtag_debug_initiator.sv
// tb_jtag_debug_initiator: directed scoreboard bench; instance 0 uses TCK_DIV=2, instance 1 uses TCK_DIV=1
module tb_jtag_debug_initiator;
  import jtag_debug_pkg::*;
  localparam int W = 38;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset [2];
  logic cmd_valid [2];
  logic cmd_ready [2];
  logic [1:0] cmd_ir [2];
  logic [W-1:0] cmd_dr [2];
  logic resp_valid [2];
  logic resp_ready [2];
  logic [W-1:0] resp_dr [2];
  logic vji_tck [2], vji_tdi [2], vji_tdo [2];
  logic [1:0] vji_ir_in [2];
  logic vji_uir [2], vji_cdr [2], vji_sdr [2], vji_udr [2], vji_rti [2];
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
  logic [15:0] scan_count [2];
`endif
  for (genvar g = 0; g < 2; g++) begin : g_dut
    jtag_debug_initiator #(.DR_WIDTH(W), .TCK_DIV(g == 0 ? 2 : 1)) dut (
      .clk(clk), .reset(reset[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_ir(cmd_ir[g]), .cmd_dr(cmd_dr[g]),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_dr(resp_dr[g]),
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
      .scan_count(scan_count[g]),
`endif
      .vji_tck(vji_tck[g]), .vji_tdi(vji_tdi[g]), .vji_tdo(vji_tdo[g]), .vji_ir_in(vji_ir_in[g]),
      .vji_uir(vji_uir[g]), .vji_cdr(vji_cdr[g]), .vji_sdr(vji_sdr[g]), .vji_udr(vji_udr[g]), .vji_rti(vji_rti[g])
    );
  end
  // TDO source for instance 0: 0 loopback, 1 constant one, 2 constant zero, 3 bench pattern
  logic [1:0] tdo_mode;
  logic [W-1:0] pat, pat_sh;
  int sdr_base;
  int rc [5];
  int pc [5];
  int rc_all;
  logic [4:0] sv;
  logic [4:0] prev_sv = '0;
  logic onehot_bad = 1'b0;
  logic [W-1:0] tdi_cap;
  assign pat_sh = pat >> (rc[2] - sdr_base);
  assign vji_tdo[0] = tdo_mode == 2'd0 ? vji_tdi[0] : tdo_mode == 2'd3 ? pat_sh[0] : tdo_mode == 2'd1;
  assign vji_tdo[1] = vji_tdi[1];
  assign sv = {vji_rti[0], vji_udr[0], vji_sdr[0], vji_cdr[0], vji_uir[0]};
  always @(posedge vji_tck[0]) begin
    rc_all <= rc_all + 1;
    for (int i = 0; i < 5; i++) if (sv[i]) rc[i] <= rc[i] + 1;
    if (vji_sdr[0]) tdi_cap <= {vji_tdi[0], tdi_cap[W-1:1]};
  end
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) if (sv[i] && !prev_sv[i]) pc[i] <= pc[i] + 1;
    prev_sv <= sv;
    if ($countones(sv) > 1) onehot_bad <= 1'b1;
  end
  int n_chk, n_err;
  logic [W-1:0] exp_q [$];
  int sc_exp [2];
  int rc_base [5];
  int pc_base [5];
  logic [1:0] last_ir;
  logic [W-1:0] last_dr;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic chk_reset(input int d, input string tag);
    chk(tag, 64'({cmd_ready[d], resp_valid[d], resp_dr[d], vji_tck[d], vji_tdi[d], vji_ir_in[d],
                  vji_uir[d], vji_cdr[d], vji_sdr[d], vji_udr[d], vji_rti[d]}),
        64'({1'b1, 1'b0, 38'd0, 1'b0, 1'b0, 2'b00, 5'b00000}));
  endtask
  task automatic start_cmd(input int d, input logic [1:0] ir, input logic [W-1:0] dr, input logic [W-1:0] e);
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready[d]), 64'(1));
    last_ir = ir;
    last_dr = dr;
    rc_base = rc;
    pc_base = pc;
    sdr_base = rc[2];
    cmd_valid[d] = 1'b1;
    cmd_ir[d] = ir;
    cmd_dr[d] = dr;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    chk("cmd_ready_busy", 64'(cmd_ready[d]), 64'(0));
  endtask
  task automatic finish_cmd(input int d, input int hold);
    int lat = 0;
    int tck0;
    logic bad = 1'b0;
    logic [W-1:0] held;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid[d] && lat < 1000);
    chk("latency", 64'(lat), 64'((W + 4) * 2 * (d == 0 ? 2 : 1)));
    chk("resp_dr", 64'(resp_dr[d]), 64'(exp_q.pop_front()));
    chk("ir_in", 64'(vji_ir_in[d]), 64'(last_ir));
    if (d == 0) begin
      chk("tck_rises", 64'({8'(rc[0] - rc_base[0]), 8'(rc[1] - rc_base[1]), 8'(rc[2] - rc_base[2]),
                            8'(rc[3] - rc_base[3]), 8'(rc[4] - rc_base[4])}),
          64'({8'd1, 8'd1, 8'd38, 8'd1, 8'd1}));
      chk("strobe_pulses", 64'({8'(pc[0] - pc_base[0]), 8'(pc[1] - pc_base[1]), 8'(pc[2] - pc_base[2]),
                                8'(pc[3] - pc_base[3]), 8'(pc[4] - pc_base[4])}),
          64'({8'd1, 8'd1, 8'd1, 8'd1, 8'd1}));
      chk("onehot", 64'(onehot_bad), 64'(0));
      chk("tdi_seq", 64'(tdi_cap), 64'(last_dr));
    end
    held = resp_dr[d];
    tck0 = rc_all;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid[d] || resp_dr[d] !== held || cmd_ready[d] || vji_tck[d]) bad = 1'b1;
    end
    if (d == 0 && rc_all != tck0) bad = 1'b1;
    chk("backpressure", 64'(bad), 64'(0));
    chk("cmd_ready_resp", 64'(cmd_ready[d]), 64'(0));
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    sc_exp[d]++;
    chk("resp_done", 64'({resp_valid[d], cmd_ready[d]}), 64'(2'b01));
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
    chk("scan_count", 64'(scan_count[d]), 64'(sc_exp[d]));
`endif
  endtask
  initial begin
    int t = 0;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      cmd_valid[d] = 1'b0;
      resp_ready[d] = 1'b0;
      cmd_ir[d] = 2'b00;
      cmd_dr[d] = '0;
    end
    tdo_mode = 2'd0;
    pat = '0;
    sdr_base = 0;
    repeat (3) @(negedge clk);
    chk_reset(0, "reset_a");
    chk_reset(1, "reset_b");
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    chk_reset(0, "released_a");
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
    chk("scan_count_rst", 64'(scan_count[0]), 64'(0));
`endif
    start_cmd(0, IR_BREAK, 38'h2A_5A5A_A5A5, 38'h2A_5A5A_A5A5);
    finish_cmd(0, 0);
    tdo_mode = 2'd1;
    start_cmd(0, IR_TRACE, 38'h12_3456_789A, '1);
    finish_cmd(0, 2);
    tdo_mode = 2'd2;
    start_cmd(0, IR_TRACECTRL, 38'h3F_FFFF_0000, '0);
    finish_cmd(0, 0);
    tdo_mode = 2'd3;
    pat = 38'h15_0F0F_3C3C;
    start_cmd(0, IR_OCIMEM, 38'h0A_F0F0_C3C3, pat);
    finish_cmd(0, 50);
    tdo_mode = 2'd0;
    start_cmd(0, IR_BREAK, 38'h33_CCCC_3333, 38'h33_CCCC_3333);
    while (rc[2] - sdr_base < 20 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_bit20", 64'(t < 1000), 64'(1));
    reset[0] = 1'b1;
    #1;
    chk_reset(0, "reset_mid");
    exp_q.delete();
    sc_exp[0] = 0;
    @(negedge clk);
    reset[0] = 1'b0;
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
    chk("scan_count_abort", 64'(scan_count[0]), 64'(0));
`endif
    tdo_mode = 2'd3;
    pat = 38'h2B_DEAD_BEEF;
    start_cmd(0, IR_TRACE, 38'h01_2345_6789, pat);
    finish_cmd(0, 5);
    start_cmd(1, IR_TRACE, 38'h3F_0000_FFFF, 38'h3F_0000_FFFF);
    finish_cmd(1, 0);
    start_cmd(1, IR_BREAK, 38'h00_AAAA_5555, 38'h00_AAAA_5555);
    finish_cmd(1, 3);
    start_cmd(1, IR_OCIMEM, 38'h2A_5A5A_A5A5, 38'h2A_5A5A_A5A5);
    finish_cmd(1, 0);
`ifdef JTAG_DEBUG_INIT_SCAN_COUNT_EN
    chk("scan_count_b", 64'(scan_count[1]), 64'(3));
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
